ddu_run_ctrl: RTL
=================

// Module: ddu_run_ctrl
// PURPOSE
//  Run-control front end for the debug unit of the multicycle CPU. Conditions the
//  cont switch and step button, then drives the CPU run enable. Stops only on
//  instruction boundaries, using the CPU's instr_done pulse.
//  Sits between the board inputs and the CPU clock-enable; the display path consumes its status.
// PARAMETERS
//  DB_CYCLES  1000000  consecutive stable cycles required to accept an input change (10 ms @ 100 MHz)
//  DB_W       20       debounce counter width; must satisfy 2**DB_W > DB_CYCLES
// PORTS
//  clk         in   1   system clock; all state on rising edge
//  rst         in   1   asynchronous, active-low reset
//  cont_in     in   1   raw continuous-run switch (level, asynchronous)
//  step_in     in   1   raw single-step button (asynchronous)
//  instr_done  in   1   CPU pulse: last state of an instruction completes this cycle
//  run         out  1   CPU run enable (registered)
//  state       out  2   FSM state: 0 IDLE, 1 CONT, 2 STEP, 3 FINISH
//  instr_cnt   out  16  instructions retired while run=1, wraps
//  step_ack    out  1   one-cycle pulse when a step request is accepted
// BEHAVIOUR
//  Reset (rst=0, async): sync flops, debounced levels, counters = 0; state=IDLE, run=0,
//   instr_cnt=0, step_ack=0. Reset mid-instruction drops run immediately; no completion.
//  Sync: two-flop synchronizer per raw input.
//  Debounce, per input:
//   - If synced != debounced level, the counter increments; otherwise it clears.
//   - When the counter reaches DB_CYCLES-1 with synced still differing, the debounced
//     level flips on the next edge and the counter clears.
//   - Glitches shorter than DB_CYCLES are rejected.
//  step_rise: one-cycle pulse on a debounced step 0->1 edge. Releasing step has no effect.
//  FSM (evaluated each cycle, priority top-down):
//   IDLE:   cont_db=1 -> CONT; else step_rise -> STEP (step_ack=1 that cycle).
//   CONT:   cont_db=0 & instr_done -> IDLE; cont_db=0 -> FINISH; else stay.
//   STEP:   cont_db=1 -> CONT; instr_done -> IDLE; step_rise ignored (no ack).
//   FINISH: cont_db=1 -> CONT; instr_done -> IDLE.
//  run = registered (next_state != IDLE): run rises the cycle after step_rise/cont_db
//   and falls the cycle after the accepted instr_done.
//  instr_cnt: +1 on instr_done while run=1; 0xFFFF wraps to 0x0000. instr_done while run=0 is ignored.
//  A step_rise in the same cycle as instr_done in STEP is dropped (STEP->IDLE), not queued.
//  step_ack: high only on the IDLE->STEP transition cycle; otherwise 0.
// TESTING (bench uses DB_CYCLES=4, DB_W=3)
//  Reset: assert rst=0 mid-CONT -> run=0, state=0, instr_cnt=0 without waiting for a clock.
//  Glitch: step_in high 3 cycles then low -> no step_ack, run stays 0, state=0.
//  Single step:
//   - Hold step_in high -> step_ack pulses once after sync+debounce (2+4 cycles), then run=1.
//   - Pulse instr_done after 5 cycles -> run=0 next cycle, instr_cnt=1.
//   - Holding step_in throughout yields no second step.
//  Continuous:
//   - cont_in=1 -> state=1, run=1; pulse instr_done 3 times -> instr_cnt=3.
//   - cont_in=0 mid-instruction -> state=3, run stays 1 until next instr_done, then state=0.
//  Boundaries:
//   - Preload 0xFFFF retirements; one more instr_done -> instr_cnt=0x0000.
//   - In STEP, set cont_in=1 before instr_done -> state=1, run never drops.
//   - instr_done with run=0 -> instr_cnt unchanged.

Source files
------------

// File: rtl/ddu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ddu_run_ctrl
//  Purpose  : Run-control front end for the debug unit. Synchronises and
//             debounces the continuous-run switch and single-step button,
//             then drives the CPU run enable. Stopping is deferred to an
//             instruction boundary signalled by instr_done.
//  Revision : 1.0 - initial release
// ============================================================================
module ddu_run_ctrl #(
    parameter int DB_CYCLES = 1000000,  // stable cycles needed to accept a change
    parameter int DB_W      = 20        // debounce counter width, 2**DB_W > DB_CYCLES
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        cont_in,
    input  logic        step_in,
    input  logic        instr_done,
    output logic        run,
    output logic [1:0]  state,
    output logic [15:0] instr_cnt,
    output logic        step_ack
);

    // Channel indices into the conditioned-input vectors
    localparam int c_CH_CONT = 0;
    localparam int c_CH_STEP = 1;

    // Debounce terminal count and increment
    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] c_DB_ONE  = DB_W'(1);
    localparam logic [15:0]     c_CNT_ONE = 16'd1;

    // Run-control state encoding (visible on the state output)
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CONT   = 2'd1;
    localparam logic [1:0] c_STEP   = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_db;
    logic [DB_W-1:0] r_db_cnt [2];
    logic            r_step_db_d;

    logic [1:0]      r_state;
    logic            r_run;
    logic            r_step_ack;
    logic [15:0]     r_instr_cnt;

    logic            w_cont_db;
    logic            w_step_rise;
    logic [1:0]      w_state_nxt;
    logic            w_ack_nxt;

    // Two-flop synchronisers and per-channel debounce counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_db        <= '0;
            r_step_db_d <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1     <= {step_in, cont_in};
            r_sync2     <= r_sync1;
            r_step_db_d <= r_db[c_CH_STEP];
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    // Accept the new level only after it has differed for
                    // DB_CYCLES consecutive cycles
                    if (r_db_cnt[i] == c_DB_LAST) begin
                        r_db[i]     <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + c_DB_ONE;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_cont_db   = r_db[c_CH_CONT];
    assign w_step_rise = r_db[c_CH_STEP] & ~r_step_db_d;

    // Next-state decision; a step press only counts when fully idle
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_cont_db) begin
                    w_state_nxt = c_CONT;
                end else if (w_step_rise) begin
                    w_state_nxt = c_STEP;
                    w_ack_nxt   = 1'b1;
                end
            end
            c_CONT: begin
                // Leaving continuous mode waits for the instruction boundary
                if (!w_cont_db) begin
                    w_state_nxt = instr_done ? c_IDLE : c_FINISH;
                end
            end
            c_STEP, c_FINISH: begin
                if (w_cont_db) begin
                    w_state_nxt = c_CONT;
                end else if (instr_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State, registered run/ack outputs and retired-instruction counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_run       <= 1'b0;
            r_step_ack  <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_run      <= (w_state_nxt != c_IDLE);
            r_step_ack <= w_ack_nxt;
            if (instr_done && r_run) begin
                r_instr_cnt <= r_instr_cnt + c_CNT_ONE;
            end
        end
    end

    assign run       = r_run;
    assign state     = r_state;
    assign instr_cnt = r_instr_cnt;
    assign step_ack  = r_step_ack;

endmodule
`default_nettype wire
